// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a single outstanding memory
// request and a 2-entry {inst, pc} buffer towards decode.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   imem_req/addr      fetch request and its byte address
//   imem_gnt           memory accepts the request (imem_req & imem_gnt)
//   imem_rvalid/rdata  in-order response, one per accepted request
//   redirect/_pc       taken branch/jump pulse and its target address
//   inst_valid/inst    head of the instruction buffer
//   inst_pc            byte address of the head instruction
//   inst_ready         decode accepts the head (inst_valid & inst_ready)
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    input  logic        inst_ready
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] DISCARD = 2'd3;

    localparam logic [15:0] PC0 = {RESET_PC[15:1], 1'b0};

    logic [1:0]  state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] req_pc_q, req_pc_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] e0_inst_q, e0_inst_d;
    logic [15:0] e0_pc_q, e0_pc_d;
    logic [15:0] e1_inst_q, e1_inst_d;
    logic [15:0] e1_pc_q, e1_pc_d;

    logic        outstanding;
    logic        credit;
    logic        push;
    logic        pop;
    logic [1:0]  cnt_after;

    // A response still owed by memory reserves a buffer slot.
    assign outstanding = (state_q == WAIT) || (state_q == DISCARD);
    assign credit = ({1'b0, count_q} + {2'b00, outstanding}) < 3'd2;

    assign imem_addr  = fetch_pc_q;
    assign inst_valid = (count_q != 2'd0);
    assign inst       = e0_inst_q;
    assign inst_pc    = e0_pc_q;

    // A redirect turns a same-cycle pop into a no-op: the flush wins.
    assign pop       = inst_valid & inst_ready & ~redirect;
    assign cnt_after = count_q - {1'b0, pop};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        imem_req   = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = credit & ~redirect;
                if (imem_req && imem_gnt) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 16'd2;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push    = ~redirect;
                    state_d = FETCH;
                end else if (redirect) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
        endcase
        if (redirect) begin
            fetch_pc_d = {redirect_pc[15:1], 1'b0};
        end
    end

    // Entry 0 is the head. It only changes on a shift or a write into it,
    // so inst/inst_pc keep their last value once the buffer drains.
    always_comb begin
        count_d   = count_q;
        e0_inst_d = e0_inst_q;
        e0_pc_d   = e0_pc_q;
        e1_inst_d = e1_inst_q;
        e1_pc_d   = e1_pc_q;
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            if (pop && (count_q == 2'd2)) begin
                e0_inst_d = e1_inst_q;
                e0_pc_d   = e1_pc_q;
            end
            if (push) begin
                if (cnt_after == 2'd0) begin
                    e0_inst_d = imem_rdata;
                    e0_pc_d   = req_pc_q;
                end else begin
                    e1_inst_d = imem_rdata;
                    e1_pc_d   = req_pc_q;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= PC0;
            req_pc_q   <= 16'h0000;
            count_q    <= 2'd0;
            e0_inst_q  <= 16'h0000;
            e0_pc_q    <= 16'h0000;
            e1_inst_q  <= 16'h0000;
            e1_pc_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            e0_inst_q  <= e0_inst_d;
            e0_pc_q    <= e0_pc_d;
            e1_inst_q  <= e1_inst_d;
            e1_pc_q    <= e1_pc_d;
        end
    end

    // Credit makes a push into a full buffer impossible; a response while
    // nothing is outstanding is a memory protocol error and is ignored.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && (count_q == 2'd2)));
            assert (!(imem_rvalid && ((state_q == IDLE) || (state_q == FETCH))));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus for fetch_unit, checked
// against a program-order reference model of requests and deliveries.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    int checks = 0;
    int errors = 0;

    // Memory model and program-order reference.
    logic        mem_busy;
    logic        mem_stale;
    logic [15:0] mem_addr;
    int          mem_delay;
    int          min_lat;
    int          max_lat;
    logic [15:0] req_exp;
    logic [15:0] exp_pc;
    int          occ;
    logic        prev_rd;
    logic        s_valid;
    logic        s_req;
    logic [15:0] s_pc;
    logic [15:0] acc_log[$];
    logic [15:0] xfer_log[$];

    function automatic logic [15:0] memf(input logic [15:0] a);
        logic [15:0] m;
        m = a * 16'd40503;
        return m ^ 16'h3C5A;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mem_busy  = 1'b0;
        mem_stale = 1'b0;
        mem_addr  = 16'h0000;
        mem_delay = 0;
        occ       = 0;
        req_exp   = 16'h0100;
        exp_pc    = 16'h0100;
        prev_rd   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, {15'd0, imem_req}, 16'h0000);
        chk({tag, "_addr"}, imem_addr, 16'h0100);
        chk({tag, "_valid"}, {15'd0, inst_valid}, 16'h0000);
        chk({tag, "_inst"}, inst, 16'h0000);
        chk({tag, "_pc"}, inst_pc, 16'h0000);
    endtask

    // Release reset at a falling edge: the first cycle is IDLE (no request),
    // the request appears after the next rising edge.
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_req", {15'd0, imem_req}, 16'h0000);
        chk("idle_addr", imem_addr, 16'h0100);
    endtask

    task automatic cyc(input logic rd, input logic [15:0] tg,
                       input logic ry, input logic g);
        logic        acc;
        logic        xfer;
        logic        rv;
        logic        exp_req;
        logic [15:0] a;
        logic [15:0] p;
        @(negedge clk);
        redirect    = rd;
        redirect_pc = tg;
        inst_ready  = ry;
        imem_gnt    = g;
        rv          = mem_busy && (mem_delay == 0);
        imem_rvalid = rv;
        imem_rdata  = rv ? memf(mem_addr) : 16'($urandom);
        #1;
        exp_req = !mem_busy && (occ < 2) && !rd;
        chk("req", {15'd0, imem_req}, {15'd0, exp_req});
        chk("valid", {15'd0, inst_valid}, {15'd0, occ != 0});
        if (prev_rd) chk("flush", {15'd0, inst_valid}, 16'h0000);
        s_valid = inst_valid;
        s_req   = imem_req;
        s_pc    = inst_pc;
        acc     = imem_req & imem_gnt;
        a       = imem_addr;
        p       = inst_pc;
        if (acc) chk("addr", imem_addr, req_exp);
        xfer = inst_valid & ry & ~rd;
        if (xfer) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, memf(exp_pc));
        end
        @(posedge clk);
        if (rv) begin
            mem_busy = 1'b0;
            if (!mem_stale && !rd) occ++;
        end else if (mem_busy) begin
            mem_delay--;
        end
        if (xfer) begin
            occ--;
            exp_pc = exp_pc + 16'd2;
            xfer_log.push_back(p);
        end
        if (acc) begin
            mem_busy  = 1'b1;
            mem_stale = 1'b0;
            mem_addr  = a;
            mem_delay = $urandom_range(max_lat, min_lat);
            req_exp   = req_exp + 16'd2;
            acc_log.push_back(a);
        end
        if (rd) begin
            occ     = 0;
            req_exp = tg & 16'hFFFE;
            exp_pc  = tg & 16'hFFFE;
            if (mem_busy) mem_stale = 1'b1;
        end
        prev_rd = rd;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        xfer_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        model_reset();
        min_lat = 0;
        max_lat = 0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_vals("rst");

        // Reset release, 1-cycle memory, decode always ready.
        release_reset();
        clear_logs();
        repeat (8) cyc(1'b0, 16'h0, 1'b1, 1'b1);
        chk("r29_nacc", 16'(acc_log.size() >= 3), 16'h0001);
        chk("r29_acc0", acc_log[0], 16'h0100);
        chk("r29_acc1", acc_log[1], 16'h0102);
        chk("r29_acc2", acc_log[2], 16'h0104);
        chk("r29_pc0", xfer_log[0], 16'h0100);
        chk("r29_pc1", xfer_log[1], 16'h0102);
        chk("r29_pc2", xfer_log[2], 16'h0104);

        // Decode stalls: buffer fills with 0000 and 0002, requests stop.
        cyc(1'b1, 16'h0000, 1'b0, 1'b1);
        clear_logs();
        repeat (10) cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("r30_nacc", 16'(acc_log.size()), 16'd2);
        chk("r30_full_valid", {15'd0, s_valid}, 16'h0001);
        chk("r30_full_pc", s_pc, 16'h0000);
        chk("r30_full_req", {15'd0, s_req}, 16'h0000);
        clear_logs();
        repeat (8) cyc(1'b0, 16'h0, 1'b1, 1'b1);
        chk("r30_pc0", xfer_log[0], 16'h0000);
        chk("r30_pc1", xfer_log[1], 16'h0002);
        chk("r30_pc2", xfer_log[2], 16'h0004);
        chk("r30_acc0", acc_log[0], 16'h0004);

        // Redirect while waiting on the 0006 response.
        cyc(1'b1, 16'h0000, 1'b1, 1'b1);
        min_lat = 2;
        max_lat = 2;
        clear_logs();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1);
            if (acc_log.size() > 0 && acc_log[$] == 16'h0006) found = 1'b1;
        end
        chk("r31_reach", {15'd0, found}, 16'h0001);
        cyc(1'b1, 16'h0040, 1'b1, 1'b1);
        clear_logs();
        repeat (12) cyc(1'b0, 16'h0, 1'b1, 1'b1);
        chk("r31_acc0", acc_log[0], 16'h0040);
        chk("r31_pc0", xfer_log[0], 16'h0040);

        // Redirect in the same cycle as the response.
        min_lat = 0;
        max_lat = 0;
        clear_logs();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1);
            if (acc_log.size() > 0) found = 1'b1;
        end
        chk("r32_reach", {15'd0, found}, 16'h0001);
        cyc(1'b1, 16'h0200, 1'b1, 1'b1);
        clear_logs();
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        chk("r32_flush", {15'd0, s_valid}, 16'h0000);
        repeat (6) cyc(1'b0, 16'h0, 1'b1, 1'b1);
        chk("r32_acc0", acc_log[0], 16'h0200);
        chk("r32_pc0", xfer_log[0], 16'h0200);

        // Address wrap and odd redirect target.
        cyc(1'b1, 16'hFFFE, 1'b1, 1'b1);
        clear_logs();
        repeat (6) cyc(1'b0, 16'h0, 1'b1, 1'b1);
        chk("r33_acc0", acc_log[0], 16'hFFFE);
        chk("r33_acc1", acc_log[1], 16'h0000);
        chk("r33_pc1", xfer_log[1], 16'h0000);
        cyc(1'b1, 16'h0043, 1'b1, 1'b1);
        clear_logs();
        repeat (4) cyc(1'b0, 16'h0, 1'b1, 1'b1);
        chk("r33_odd", acc_log[0], 16'h0042);

        // Random traffic.
        min_lat = 0;
        max_lat = 3;
        repeat (600) begin
            cyc($urandom_range(15, 0) == 0, 16'($urandom),
                $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
        end

        // Asynchronous reset while waiting for a response.
        min_lat = 2;
        max_lat = 2;
        clear_logs();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1);
            if (acc_log.size() > 0) found = 1'b1;
        end
        chk("r34_reach", {15'd0, found}, 16'h0001);
        @(negedge clk);
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        inst_ready  = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("r34");
        model_reset();
        repeat (2) @(posedge clk);
        release_reset();
        clear_logs();
        repeat (4) cyc(1'b0, 16'h0, 1'b1, 1'b1);
        chk("r34_acc0", acc_log[0], 16'h0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
